// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: programmable-divider SCLK generator with a CPOL/CPHA
// strobe decode and a self-terminating burst of len SCLK cycles plus a CS hold tail.
module spi_sclk_engine #(
    parameter int unsigned DIV_W = 16,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             go,
    input  logic             abort,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [DIV_W-1:0] divider,
    input  logic [LEN_W-1:0] len,
    output logic             sclk,
    output logic             pos_edge,
    output logic             neg_edge,
    output logic             sample,
    output logic             launch,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

    localparam logic [LEN_W:0] TOG_ONE = {{LEN_W{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             sclk_q, sclk_d;
    logic             done_q, done_d;
    logic             cpol_l, cpol_ld;
    logic             cpha_l, cpha_ld;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_l, div_ld;
    logic [LEN_W:0]   tog_q, tog_d;
    logic             tick, leading, trailing;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            done_q  <= 1'b0;
            cpol_l  <= 1'b0;
            cpha_l  <= 1'b0;
            cnt_q   <= '0;
            div_l   <= '0;
            tog_q   <= '0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            done_q  <= done_d;
            cpol_l  <= cpol_ld;
            cpha_l  <= cpha_ld;
            cnt_q   <= cnt_d;
            div_l   <= div_ld;
            tog_q   <= tog_d;
        end
    end

    // len=0 loads 2*2^LEN_W, which wraps to 0; the modulo countdown still
    // reaches 1 after exactly 2^(LEN_W+1)-1 ticks, giving the full burst.
    always_comb begin
        state_d = state_q;
        sclk_d  = sclk_q;
        done_d  = 1'b0;
        cpol_ld = cpol_l;
        cpha_ld = cpha_l;
        cnt_d   = cnt_q;
        div_ld  = div_l;
        tog_d   = tog_q;
        if (abort) begin
            state_d = IDLE;
            sclk_d  = cpol;
            cnt_d   = '0;
            tog_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    sclk_d = cpol;
                    if (go) begin
                        cpol_ld = cpol;
                        cpha_ld = cpha;
                        div_ld  = divider;
                        cnt_d   = divider;
                        tog_d   = {len, 1'b0};
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (cnt_q == '0) begin
                        sclk_d = ~sclk_q;
                        tog_d  = tog_q - 1'b1;
                        cnt_d  = div_l;
                        if (tog_q == TOG_ONE) state_d = TAIL;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                TAIL: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick     = (state_q == RUN) && (cnt_q == '0) && !abort;
        leading  = tick && (sclk_q == cpol_l);
        trailing = tick && (sclk_q != cpol_l);
        pos_edge = tick && !sclk_q;
        neg_edge = tick && sclk_q;
        sample   = cpha_l ? trailing : leading;
        launch   = cpha_l ? leading : (trailing && (tog_q != TOG_ONE));
    end

    assign sclk = sclk_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine: cycle-exact vector table plus multi-cycle sequences.
module tb_spi_sclk_engine;

    logic        clk_in = 1'b0;
    logic        rst_n, go, abort, cpol, cpha;
    logic [15:0] divider;
    logic [7:0]  len;
    logic        sclk, pos_edge, neg_edge, sample, launch, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        go, abort, cpol, cpha;
        logic [15:0] div;
        logic [7:0]  len;
        logic [6:0]  exp; // {sclk,pos_edge,neg_edge,sample,launch,busy,done}
    } vec_t;
    vec_t vecs[$];

    spi_sclk_engine #(.DIV_W(16), .LEN_W(8)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .go(go), .abort(abort), .cpol(cpol),
        .cpha(cpha), .divider(divider), .len(len), .sclk(sclk),
        .pos_edge(pos_edge), .neg_edge(neg_edge), .sample(sample),
        .launch(launch), .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [6:0] outs();
        return {sclk, pos_edge, neg_edge, sample, launch, busy, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic add(input logic g, input logic ab, input logic cp, input logic ch,
                       input logic [15:0] d, input logic [7:0] l, input logic [6:0] e);
        vecs.push_back('{g, ab, cp, ch, d, l, e});
    endtask

    // go must already be driven; counts strobes until two cycles after the first done.
    task automatic burst(input int maxc, output int smp, output int lch,
                         output int tog, output int dn);
        logic prev;
        int   tail;
        smp = 0; lch = 0; tog = 0; dn = 0; tail = -1;
        prev = sclk;
        for (int c = 0; c < maxc && tail != 0; c++) begin
            #1;
            if (sample) smp++;
            if (launch) lch++;
            if (done) dn++;
            if (sclk !== prev) tog++;
            prev = sclk;
            if (dn > 0 && tail < 0) tail = 2;
            else if (tail > 0) tail--;
            step();
            go = 1'b0;
        end
    endtask

    task automatic wait_idle(input int maxc);
        for (int c = 0; c < maxc && busy; c++) step();
        check("wait_idle_busy", busy, 0);
    endtask

    initial begin
        int   smp, lch, tog, dn, t_pos, t_neg, tg;
        logic prev;

        // Mode 0: divider=1, len=2; go sampled at E0
        add(0,0,0,0,16'd1,8'd2, 7'b0000000);
        add(1,0,0,0,16'd1,8'd2, 7'b0000000);
        add(0,0,0,0,16'd1,8'd2, 7'b0000010);
        add(0,0,0,0,16'd1,8'd2, 7'b0101010);
        add(0,0,0,0,16'd1,8'd2, 7'b1000010);
        add(0,0,0,0,16'd1,8'd2, 7'b1010110);
        add(1,0,0,0,16'd1,8'd2, 7'b0000010); // go mid-burst ignored
        add(0,0,0,0,16'd1,8'd2, 7'b0101010);
        add(0,0,0,0,16'd1,8'd2, 7'b1000010);
        add(0,0,0,0,16'd1,8'd2, 7'b1010010); // final trailing edge: no launch
        add(0,0,0,0,16'd1,8'd2, 7'b0000010);
        add(0,0,0,0,16'd1,8'd2, 7'b0000010);
        add(0,0,0,0,16'd1,8'd2, 7'b0000001);
        add(0,0,0,0,16'd1,8'd2, 7'b0000000);
        // Idle polarity follows cpol one cycle later
        add(0,0,1,1,16'd0,8'd3, 7'b0000000);
        add(0,0,1,1,16'd0,8'd3, 7'b1000000);
        // Mode 3: divider=0, len=3
        add(1,0,1,1,16'd0,8'd3, 7'b1000000);
        add(0,0,1,1,16'd0,8'd3, 7'b1010110);
        add(0,0,1,1,16'd0,8'd3, 7'b0101010);
        add(0,0,1,1,16'd0,8'd3, 7'b1010110);
        add(0,0,1,1,16'd0,8'd3, 7'b0101010);
        add(0,0,1,1,16'd0,8'd3, 7'b1010110);
        add(0,0,1,1,16'd0,8'd3, 7'b0101010);
        add(0,0,1,1,16'd0,8'd3, 7'b1000010);
        add(0,0,1,1,16'd0,8'd3, 7'b1000001);
        add(0,0,0,0,16'd0,8'd3, 7'b1000000);
        add(0,0,0,0,16'd0,8'd3, 7'b0000000);

        rst_n = 1'b0; go = 1'b0; abort = 1'b0; cpol = 1'b1; cpha = 1'b0;
        divider = 16'd0; len = 8'd0;
        step(); step(); #1;
        check("reset_outputs", outs(), 7'b0000000);
        rst_n = 1'b1; cpol = 1'b0;
        step(); step();

        foreach (vecs[i]) begin
            go = vecs[i].go; abort = vecs[i].abort; cpol = vecs[i].cpol;
            cpha = vecs[i].cpha; divider = vecs[i].div; len = vecs[i].len;
            #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
            step();
        end
        go = 1'b0;

        // len=0 -> full 256-cycle burst
        cpol = 1'b0; cpha = 1'b0; divider = 16'd0; len = 8'd0; go = 1'b1;
        burst(2000, smp, lch, tog, dn);
        check("len0_samples", smp, 256);
        check("len0_launches", lch, 255);
        check("len0_toggles", tog, 512);
        check("len0_done", dn, 1);

        // divider change mid-burst must not alter the latched half-period
        divider = 16'd3; len = 8'd2; go = 1'b1;
        step(); go = 1'b0; divider = 16'd0;
        t_pos = -1; t_neg = -1;
        for (int c = 0; c < 60 && t_neg < 0; c++) begin
            #1;
            if (pos_edge && t_pos < 0) t_pos = c;
            else if (neg_edge && t_pos >= 0) t_neg = c;
            step();
        end
        check("div_first_edge", t_pos, 3);
        check("div_half_period", t_neg - t_pos, 4);
        wait_idle(100);

        // abort after 3 toggles
        cpol = 1'b0; cpha = 1'b0; divider = 16'd1; len = 8'd4; go = 1'b1;
        step(); go = 1'b0;
        tg = 0; prev = sclk;
        for (int c = 0; c < 50 && tg < 3; c++) begin
            #1;
            if (sclk !== prev) tg++;
            prev = sclk;
            if (tg < 3) step();
        end
        check("abort_pre_toggles", tg, 3);
        check("abort_pre_sclk", sclk, 1);
        abort = 1'b1; #1;
        check("abort_strobes", {pos_edge, neg_edge, sample, launch}, 4'b0000);
        step(); abort = 1'b0; #1;
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        dn = 0;
        for (int c = 0; c < 2; c++) begin
            step(); #1;
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        go = 1'b1;
        burst(200, smp, lch, tog, dn);
        check("post_abort_samples", smp, 4);
        check("post_abort_toggles", tog, 8);
        check("post_abort_done", dn, 1);

        // asynchronous reset mid-burst
        divider = 16'd2; len = 8'd3; go = 1'b1;
        step(); go = 1'b0;
        repeat (3) step();
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_sclk", sclk, 1);
        rst_n = 1'b0; #1;
        check("rst_async", {sclk, busy, done}, 3'b000);
        step(); step();
        rst_n = 1'b1;
        step(); step(); #1;
        check("rst_after_release", {sclk, busy, done}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
